// File: rtl/n2_ict_pkg.sv
// Shared types and widths for the I-cache tag-array request arbiter.
package n2_ict_pkg;
  localparam int IDX_W = 6;
  localparam int WAY_W = 3;
  localparam int TAG_W = 30;
  localparam int CNT_W = 9;

  localparam logic [TAG_W-1:0] INV_TAG = 30'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } ict_state_e;
endpackage

// File: rtl/n2_ict_sweep_cnt.sv
// Invalidate-sweep counter: walks {index,way} across the whole tag array.
module n2_ict_sweep_cnt
  import n2_ict_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/n2_ict_req_arb.sv
// Tag-array port arbiter: fetch reads, fill writes and invalidate-all sweeps.
// Optional fill anti-starvation counter enabled by ICT_FILL_STARVE_EN.
module n2_ict_req_arb
  import n2_ict_pkg::*;
#(
  parameter int FILL_STARVE_MAX = 4
) (
  input  logic        l2clk,
  input  logic        rst_l,
  input  logic        tcu_array_wr_inhibit,
  input  logic        fet_rd_vld,
  input  logic [10:5] fet_rd_index,
  output logic        fet_rd_gnt,
  input  logic        fill_vld,
  input  logic [10:5] fill_index,
  input  logic [2:0]  fill_way,
  input  logic [29:0] fill_tag,
  output logic        fill_rdy,
  input  logic        inv_all_req,
  output logic        inv_busy,
  output logic        inv_done,
  output logic        ftp_tg_rd_req_bf,
  output logic        ftp_tg_wr_req_bf,
  output logic        ftp_tg_clk_en,
  output logic [10:5] agd_ic_index_bf,
  output logic [2:0]  agc_fill_wrway_bf,
  output logic [29:0] agd_ict_wrtag_bf
);

  if (FILL_STARVE_MAX < 1) begin : g_bad_starve_max
    $error("FILL_STARVE_MAX must be at least 1");
  end

  ict_state_e       state_q, state_d;
  logic             inv_pend_q, inv_pend_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last, cnt_clr, sweep_wr;
  logic             starve_hit, fill_acc;

  logic             rd_q, rd_d, wr_q, wr_d, act_q;
  logic [10:5]      idx_q, idx_d;
  logic [2:0]       way_q, way_d;
  logic [29:0]      tag_q, tag_d;

  // Arbitration only happens in IDLE; the sweep owns the array otherwise.
  always_comb begin
    fet_rd_gnt = 1'b0;
    fill_rdy   = 1'b0;
    if (state_q == ST_IDLE) begin
      fill_rdy   = !tcu_array_wr_inhibit && (!fet_rd_vld || starve_hit);
      fet_rd_gnt = fet_rd_vld && !(fill_vld && fill_rdy);
    end
  end

  assign fill_acc = fill_vld & fill_rdy;
  assign sweep_wr = (state_q == ST_SWEEP) & ~tcu_array_wr_inhibit;

`ifdef ICT_FILL_STARVE_EN
  localparam int SW = (FILL_STARVE_MAX < 1) ? 1 : $clog2(FILL_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(FILL_STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == STARVE_MAX);

  // Counts lost cycles, including ones lost to write inhibit or a sweep.
  always_comb begin
    starve_d = starve_q;
    if (fill_acc)                      starve_d = '0;
    else if (fill_vld && !starve_hit)  starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge l2clk or negedge rst_l) begin
    if (!rst_l) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    inv_pend_d = inv_pend_q;
    cnt_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inv_all_req) begin
          state_d = ST_SWEEP;
          cnt_clr = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (inv_all_req)          inv_pend_d = 1'b1;
        if (sweep_wr && cnt_last) state_d    = ST_DONE;
      end
      ST_DONE: begin
        inv_pend_d = 1'b0;
        if (inv_pend_q || inv_all_req) begin
          state_d = ST_SWEEP;
          cnt_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge l2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  n2_ict_sweep_cnt u_sweep_cnt (
    .clk_i  (l2clk),
    .rst_ni (rst_l),
    .clr_i  (cnt_clr),
    .inc_i  (sweep_wr),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // Way and tag only move on writes so a read leaves the last write visible.
  always_comb begin
    rd_d  = fet_rd_gnt;
    wr_d  = fill_acc | sweep_wr;
    idx_d = idx_q;
    way_d = way_q;
    tag_d = tag_q;
    if (fet_rd_gnt) begin
      idx_d = fet_rd_index;
    end else if (fill_acc) begin
      idx_d = fill_index;
      way_d = fill_way;
      tag_d = fill_tag;
    end else if (sweep_wr) begin
      idx_d = cnt[8:3];
      way_d = cnt[2:0];
      tag_d = INV_TAG;
    end
  end

  always_ff @(posedge l2clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      act_q <= 1'b0;
      idx_q <= '0;
      way_q <= '0;
      tag_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      act_q <= rd_q | wr_q;
      idx_q <= idx_d;
      way_q <= way_d;
      tag_q <= tag_d;
    end
  end

  assign inv_busy          = (state_q != ST_IDLE);
  assign inv_done          = (state_q == ST_DONE);
  assign ftp_tg_rd_req_bf  = rd_q;
  assign ftp_tg_wr_req_bf  = wr_q;
  assign ftp_tg_clk_en     = rd_q | wr_q | act_q;
  assign agd_ic_index_bf   = idx_q;
  assign agc_fill_wrway_bf = way_q;
  assign agd_ict_wrtag_bf  = tag_q;

endmodule

// File: doc/n2_ict_req_arb.md
N2_ICT_REQ_ARB -- requirements
Module: n2_ict_req_arb

Interface
REQ-001 The parameter FILL_STARVE_MAX SHALL default to 4 and SHALL set the number of consecutive cycles a pending fill may lose to fetch before it is forced to win.
REQ-002 The block SHALL have exactly one clock, l2clk; all state SHALL update on its rising edge.
REQ-003 The port l2clk SHALL be an input, 1 bit wide: the core clock.
REQ-004 The port rst_l SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-005 The port tcu_array_wr_inhibit SHALL be an input, 1 bit wide: while high, all tag-array writes are blocked.
REQ-006 The port fet_rd_vld SHALL be an input, 1 bit wide: fetch tag-read request.
REQ-007 The port fet_rd_index SHALL be an input, 6 bits wide [10:5]: fetch index.
REQ-008 The port fet_rd_gnt SHALL be an output, 1 bit wide: fetch granted this cycle (combinational).
REQ-009 The port fill_vld SHALL be an input, 1 bit wide: fill write request; index, way and tag held stable until accepted.
REQ-010 The port fill_index SHALL be an input, 6 bits wide [10:5]: fill index.
REQ-011 The port fill_way SHALL be an input, 3 bits wide: fill way.
REQ-012 The port fill_tag SHALL be an input, 30 bits wide: tag plus parity.
REQ-013 The port fill_rdy SHALL be an output, 1 bit wide: fill accepted when fill_vld and fill_rdy are both high (combinational).
REQ-014 The port inv_all_req SHALL be an input, 1 bit wide: one-cycle pulse that starts an invalidate sweep.
REQ-015 The port inv_busy SHALL be an output, 1 bit wide: sweep in progress.
REQ-016 The port inv_done SHALL be an output, 1 bit wide: one-cycle pulse when a sweep completes.
REQ-017 The port ftp_tg_rd_req_bf SHALL be an output, 1 bit wide: registered tag-array read request.
REQ-018 The port ftp_tg_wr_req_bf SHALL be an output, 1 bit wide: registered tag-array write request.
REQ-019 The port ftp_tg_clk_en SHALL be an output, 1 bit wide: tag-array clock enable.
REQ-020 The port agd_ic_index_bf SHALL be an output, 6 bits wide [10:5]: registered array index.
REQ-021 The port agc_fill_wrway_bf SHALL be an output, 3 bits wide: registered write way.
REQ-022 The port agd_ict_wrtag_bf SHALL be an output, 30 bits wide: registered write tag.

Function
REQ-023 The FSM SHALL have three states: IDLE (arbitrate), SWEEP (invalidate writes), DONE (one cycle, inv_done=1).
REQ-024 In IDLE, priority SHALL be fetch over fill, except that fill wins when starve_cnt==FILL_STARVE_MAX.
REQ-025 The starve_cnt SHALL increment each cycle fill_vld is high and fill_rdy is low, SHALL saturate at FILL_STARVE_MAX, and SHALL clear on fill acceptance.
REQ-026 A granted request SHALL appear on the *_bf outputs the following cycle; latency SHALL be exactly 1.
REQ-027 A read grant SHALL drive ftp_tg_rd_req_bf=1 and agd_ic_index_bf=fet_rd_index; wrway and wrtag SHALL hold their previous value.
REQ-028 A fill grant SHALL drive ftp_tg_wr_req_bf=1 and load index, way and tag from the fill inputs.
REQ-029 ftp_tg_rd_req_bf and ftp_tg_wr_req_bf SHALL never both be 1.
REQ-030 ftp_tg_clk_en SHALL equal (rd_req_bf|wr_req_bf) OR the same term delayed by one cycle.
REQ-031 inv_all_req in IDLE SHALL enter SWEEP next cycle and clear the 9-bit sweep counter; inv_busy=1 throughout SWEEP and DONE.
REQ-032 In SWEEP, each cycle SHALL issue a write with index=cnt[8:3], way=cnt[2:0], tag=30'h0, then increment cnt; fet_rd_gnt=0 and fill_rdy=0.
REQ-033 After the write at cnt==511 is issued, the FSM SHALL go to DONE, then to IDLE.
REQ-034 inv_all_req received during SWEEP or DONE SHALL set inv_pend; DONE with inv_pend set SHALL go to SWEEP (counter cleared, pend cleared) and still pulse inv_done.
REQ-035 While tcu_array_wr_inhibit=1: fill_rdy=0, no writes issue, the SWEEP counter holds, reads still arbitrate, and starve_cnt keeps counting.
REQ-036 inv_all_req coincident with a fill in IDLE SHALL let the fill be accepted that cycle and the sweep start next cycle.

Reset
REQ-037 Asserting rst_l low SHALL immediately set FSM=IDLE and clear cnt, starve_cnt, inv_pend, all *_bf outputs, clk_en, and inv_done to 0; a sweep in progress SHALL be abandoned without completion.

Configuration
REQ-038 With ICT_FILL_STARVE_EN defined, REQ-024 and REQ-025 SHALL apply; without it, starve_cnt SHALL be absent and fill SHALL win only when fet_rd_vld=0.

Structure
REQ-039 A shared package n2_ict_pkg SHALL hold the FSM state enum, the index, way and tag widths, and INV_TAG=30'h0.
REQ-040 One sub-module, n2_ict_sweep_cnt (9-bit counter with hold and clear, last flag), SHALL be used.

Verification
REQ-041 The bench SHALL drive fet_rd_vld=1, index=6'h2A with nothing else pending, and check rd_req_bf=1 and index_bf=6'h2A next cycle, with clk_en high for 2 cycles.
REQ-042 The bench SHALL drive fill (idx 6'h05, way 3, tag 30'h1234567) against continuous fetch with the macro defined, and check fill_rdy on the 5th cycle and wr_req_bf=1 with those values the next cycle.
REQ-043 The bench SHALL pulse inv_all_req and check exactly 512 writes, tag 0, order (0,0),(0,1)…(63,7), then one inv_done pulse and inv_busy low after it.
REQ-044 The bench SHALL hold wr_inhibit=1 for 10 cycles mid-sweep and check no writes, counter held, and total writes still 512.
REQ-045 The bench SHALL send a second inv_all_req at sweep write 100 and check a second full 512-write sweep follows DONE.
REQ-046 The bench SHALL assert rst_l low at sweep write 300 and check all outputs 0 asynchronously and IDLE after release.
